// File: rtl/cast5_keyex_if.sv
// Key-expansion port bundle: raw key in, expanded key out, plus the shared S5-S8 lookup lanes.
interface cast5_keyex_if;
  logic [127:0]  i_key;
  logic          i_key_en;
  logic [1023:0] o_keyex;
  logic          o_keyex_en;
  logic          o_busy;
  logic [39:0]   o_sbox_idx;
  logic [9:0]    o_sbox_sel;
  logic [159:0]  i_sbox_val;

  modport master (
    input  i_key, i_key_en, i_sbox_val,
    output o_keyex, o_keyex_en, o_busy, o_sbox_idx, o_sbox_sel
  );

  modport slave (
    output i_key, i_key_en, i_sbox_val,
    input  o_keyex, o_keyex_en, o_busy, o_sbox_idx, o_sbox_sel
  );
endinterface

// File: rtl/cast5_keyex.sv
// Iterative CAST5-128 key schedule: one 32-bit word per cycle via an external 5-lane S5-S8 bank.
// Latency 65 cycles from i_key_en to o_keyex_en; no backpressure, a new i_key_en aborts and restarts.
module cast5_keyex (
  input  logic          i_clk,
  input  logic          i_rst,
  cast5_keyex_if.master kx
);
  localparam int NSTEP = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Lane code {src, byte}: src=0 selects x state, src=1 selects z state.
  typedef struct packed {
    logic [4:0][4:0] ln;
    logic [1:0]      t4;
    logic [1:0]      dw;
    logic [1:0]      bw;
  } dec_t;

  state_t        state_q, state_d;
  logic [5:0]    step_q, step_d;
  logic [127:0]  x_q, x_d, z_q, z_d;
  logic [1023:0] hold_q, hold_d, keyex_q, keyex_d;

  dec_t          dec;
  logic [39:0]   idx;
  logic [31:0]   lane_x, base_w, word;
  logic [6:0]    wr_lsb;
  logic [9:0]    k_lsb;

  function automatic dec_t mk(input logic [4:0] a, b, c, d, e,
                              input logic [1:0] t, w, bsel);
    dec_t r;
    r.ln = {e, d, c, b, a};
    r.t4 = t;
    r.dw = w;
    r.bw = bsel;
    return r;
  endfunction

  function automatic logic [7:0] pick(input logic [4:0] c, input logic [127:0] xs,
                                      input logic [127:0] zs);
    logic [127:0] src;
    src = c[4] ? zs : xs;
    return src[{~c[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] wsel(input logic [127:0] a, input logic [1:0] i);
    return a[{~i, 5'b00000} +: 32];
  endfunction

  // Temp steps depend only on x/z direction; the schedule repeats every 32 steps.
  always_comb begin : decode
    dec = '0;
    if (!step_q[2]) begin
      unique case ({step_q[3], step_q[1:0]})
        3'b000: dec = mk(5'h0D, 5'h0F, 5'h0C, 5'h0E, 5'h08, 2'd2, 2'd0, 2'd0);
        3'b001: dec = mk(5'h10, 5'h12, 5'h11, 5'h13, 5'h0A, 2'd3, 2'd1, 2'd2);
        3'b010: dec = mk(5'h17, 5'h16, 5'h15, 5'h14, 5'h09, 2'd0, 2'd2, 2'd3);
        3'b011: dec = mk(5'h1A, 5'h19, 5'h1B, 5'h18, 5'h0B, 2'd1, 2'd3, 2'd1);
        3'b100: dec = mk(5'h15, 5'h17, 5'h14, 5'h16, 5'h10, 2'd2, 2'd0, 2'd2);
        3'b101: dec = mk(5'h00, 5'h02, 5'h01, 5'h03, 5'h12, 2'd3, 2'd1, 2'd0);
        3'b110: dec = mk(5'h07, 5'h06, 5'h05, 5'h04, 5'h11, 2'd0, 2'd2, 2'd1);
        3'b111: dec = mk(5'h0A, 5'h09, 5'h0B, 5'h08, 5'h13, 2'd1, 2'd3, 2'd3);
      endcase
    end else begin
      unique case ({step_q[4:3], step_q[1:0]})
        4'b0000: dec = mk(5'h18, 5'h19, 5'h17, 5'h16, 5'h12, step_q[1:0], 2'd0, 2'd0);
        4'b0001: dec = mk(5'h1A, 5'h1B, 5'h15, 5'h14, 5'h16, step_q[1:0], 2'd0, 2'd0);
        4'b0010: dec = mk(5'h1C, 5'h1D, 5'h13, 5'h12, 5'h19, step_q[1:0], 2'd0, 2'd0);
        4'b0011: dec = mk(5'h1E, 5'h1F, 5'h11, 5'h10, 5'h1C, step_q[1:0], 2'd0, 2'd0);
        4'b0100: dec = mk(5'h03, 5'h02, 5'h0C, 5'h0D, 5'h08, step_q[1:0], 2'd0, 2'd0);
        4'b0101: dec = mk(5'h01, 5'h00, 5'h0E, 5'h0F, 5'h0D, step_q[1:0], 2'd0, 2'd0);
        4'b0110: dec = mk(5'h07, 5'h06, 5'h08, 5'h09, 5'h03, step_q[1:0], 2'd0, 2'd0);
        4'b0111: dec = mk(5'h05, 5'h04, 5'h0A, 5'h0B, 5'h07, step_q[1:0], 2'd0, 2'd0);
        4'b1000: dec = mk(5'h13, 5'h12, 5'h1C, 5'h1D, 5'h19, step_q[1:0], 2'd0, 2'd0);
        4'b1001: dec = mk(5'h11, 5'h10, 5'h1E, 5'h1F, 5'h1C, step_q[1:0], 2'd0, 2'd0);
        4'b1010: dec = mk(5'h17, 5'h16, 5'h18, 5'h19, 5'h12, step_q[1:0], 2'd0, 2'd0);
        4'b1011: dec = mk(5'h15, 5'h14, 5'h1A, 5'h1B, 5'h16, step_q[1:0], 2'd0, 2'd0);
        4'b1100: dec = mk(5'h08, 5'h09, 5'h07, 5'h06, 5'h03, step_q[1:0], 2'd0, 2'd0);
        4'b1101: dec = mk(5'h0A, 5'h0B, 5'h05, 5'h04, 5'h07, step_q[1:0], 2'd0, 2'd0);
        4'b1110: dec = mk(5'h0C, 5'h0D, 5'h03, 5'h02, 5'h08, step_q[1:0], 2'd0, 2'd0);
        4'b1111: dec = mk(5'h0E, 5'h0F, 5'h01, 5'h00, 5'h0D, step_q[1:0], 2'd0, 2'd0);
      endcase
    end
  end

  always_comb begin : datapath
    idx    = '0;
    lane_x = '0;
    for (int n = 0; n < 5; n++) begin
      idx[8*n +: 8] = pick(dec.ln[n], x_q, z_q);
      lane_x        = lane_x ^ kx.i_sbox_val[32*n +: 32];
    end
    base_w = '0;
    if (!step_q[2]) base_w = wsel(step_q[3] ? z_q : x_q, dec.bw);
    word = base_w ^ lane_x;
  end

  assign wr_lsb = {~dec.dw, 5'b00000};
  assign k_lsb  = {~{step_q[5:3], step_q[1:0]}, 5'b00000};

  always_comb begin : next_state
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    z_d     = z_q;
    hold_d  = hold_q;
    keyex_d = keyex_q;
    if (kx.i_key_en) begin
      // A new key wins in every state; DONE still shows its pulse this cycle.
      state_d = RUN;
      step_d  = '0;
      x_d     = kx.i_key;
      z_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (!step_q[2]) begin
            if (step_q[3]) x_d[wr_lsb +: 32] = word;
            else           z_d[wr_lsb +: 32] = word;
          end else begin
            hold_d[k_lsb +: 32] = word;
          end
          if (step_q == 6'(NSTEP - 1)) begin
            state_d = DONE;
            keyex_d = hold_d;
          end else begin
            step_d = step_q + 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      x_q     <= '0;
      z_q     <= '0;
      hold_q  <= '0;
      keyex_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      z_q     <= z_d;
      hold_q  <= hold_d;
      keyex_q <= keyex_d;
    end
  end

  assign kx.o_keyex     = keyex_q;
  assign kx.o_keyex_en  = (state_q == DONE);
  assign kx.o_busy      = (state_q == RUN);
  assign kx.o_sbox_idx  = (state_q == RUN) ? idx : 40'd0;
  assign kx.o_sbox_sel  = (state_q == RUN) ? {dec.t4, 2'd3, 2'd2, 2'd1, 2'd0} : 10'd0;
endmodule

// File: tb/tb_cast5_keyex.sv
// Bench for cast5_keyex: random S-box bank, key schedule model written from the RFC 2144 equations.
module tb_cast5_keyex;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cast5_keyex_if kx ();
  cast5_keyex dut (.i_clk(clk), .i_rst(rst), .kx(kx));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   sbox_tab [4][256];
  logic [7:0]    mx [16];
  logic [7:0]    mz [16];
  logic [39:0]   mdl_idx [64];
  logic [9:0]    mdl_sel [64];
  logic [1023:0] mdl_keyex;
  logic [1023:0] exp_keyex;
  int            mdl_n;

  always_comb begin
    kx.i_sbox_val = '0;
    for (int n = 0; n < 5; n++)
      kx.i_sbox_val[32*n +: 32] = sbox_tab[kx.o_sbox_sel[2*n +: 2]][kx.o_sbox_idx[8*n +: 8]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One RFC term list: S5[b0]^S6[b1]^S7[b2]^S8[b3]^S(t4)[b4]; also records the lookups.
  function automatic logic [31:0] L(input logic [7:0] b0, b1, b2, b3,
                                    input logic [1:0] t4, input logic [7:0] b4);
    mdl_idx[mdl_n] = {b4, b3, b2, b1, b0};
    mdl_sel[mdl_n] = {t4, 2'd3, 2'd2, 2'd1, 2'd0};
    mdl_n++;
    return sbox_tab[0][b0] ^ sbox_tab[1][b1] ^ sbox_tab[2][b2] ^ sbox_tab[3][b3] ^ sbox_tab[t4][b4];
  endfunction

  function automatic logic [31:0] wx(input int i);
    return {mx[4*i], mx[4*i+1], mx[4*i+2], mx[4*i+3]};
  endfunction
  function automatic logic [31:0] wz(input int i);
    return {mz[4*i], mz[4*i+1], mz[4*i+2], mz[4*i+3]};
  endfunction

  task automatic setx(input int i, input logic [31:0] w);
    for (int j = 0; j < 4; j++) mx[4*i+j] = w[31-8*j -: 8];
  endtask
  task automatic setz(input int i, input logic [31:0] w);
    for (int j = 0; j < 4; j++) mz[4*i+j] = w[31-8*j -: 8];
  endtask
  task automatic put_k(input int i, input logic [31:0] w);
    mdl_keyex[1023-32*i -: 32] = w;
  endtask

  task automatic temps_z;
    setz(0, wx(0) ^ L(mx[13], mx[15], mx[12], mx[14], 2, mx[8]));
    setz(1, wx(2) ^ L(mz[0],  mz[2],  mz[1],  mz[3],  3, mx[10]));
    setz(2, wx(3) ^ L(mz[7],  mz[6],  mz[5],  mz[4],  0, mx[9]));
    setz(3, wx(1) ^ L(mz[10], mz[9],  mz[11], mz[8],  1, mx[11]));
  endtask

  task automatic temps_x;
    setx(0, wz(2) ^ L(mz[5],  mz[7],  mz[4],  mz[6],  2, mz[0]));
    setx(1, wz(0) ^ L(mx[0],  mx[2],  mx[1],  mx[3],  3, mz[2]));
    setx(2, wz(1) ^ L(mx[7],  mx[6],  mx[5],  mx[4],  0, mz[1]));
    setx(3, wz(3) ^ L(mx[10], mx[9],  mx[11], mx[8],  1, mz[3]));
  endtask

  task automatic model_run(input logic [127:0] key);
    mdl_n = 0;
    for (int j = 0; j < 16; j++) begin
      mx[j] = key[127-8*j -: 8];
      mz[j] = '0;
    end
    for (int h = 0; h < 2; h++) begin
      temps_z();
      put_k(16*h+0,  L(mz[8],  mz[9],  mz[7],  mz[6],  0, mz[2]));
      put_k(16*h+1,  L(mz[10], mz[11], mz[5],  mz[4],  1, mz[6]));
      put_k(16*h+2,  L(mz[12], mz[13], mz[3],  mz[2],  2, mz[9]));
      put_k(16*h+3,  L(mz[14], mz[15], mz[1],  mz[0],  3, mz[12]));
      temps_x();
      put_k(16*h+4,  L(mx[3],  mx[2],  mx[12], mx[13], 0, mx[8]));
      put_k(16*h+5,  L(mx[1],  mx[0],  mx[14], mx[15], 1, mx[13]));
      put_k(16*h+6,  L(mx[7],  mx[6],  mx[8],  mx[9],  2, mx[3]));
      put_k(16*h+7,  L(mx[5],  mx[4],  mx[10], mx[11], 3, mx[7]));
      temps_z();
      put_k(16*h+8,  L(mz[3],  mz[2],  mz[12], mz[13], 0, mz[9]));
      put_k(16*h+9,  L(mz[1],  mz[0],  mz[14], mz[15], 1, mz[12]));
      put_k(16*h+10, L(mz[7],  mz[6],  mz[8],  mz[9],  2, mz[2]));
      put_k(16*h+11, L(mz[5],  mz[4],  mz[10], mz[11], 3, mz[6]));
      temps_x();
      put_k(16*h+12, L(mx[8],  mx[9],  mx[7],  mx[6],  0, mx[3]));
      put_k(16*h+13, L(mx[10], mx[11], mx[5],  mx[4],  1, mx[7]));
      put_k(16*h+14, L(mx[12], mx[13], mx[3],  mx[2],  2, mx[8]));
      put_k(16*h+15, L(mx[14], mx[15], mx[1],  mx[0],  3, mx[13]));
    end
  endtask

  function automatic logic [127:0] rnd128;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pulses the key in the current cycle and follows it to the DONE cycle (returns inside DONE).
  task automatic expand(input logic [127:0] key);
    int bad_ctl;
    bad_ctl = 0;
    model_run(key);
    kx.i_key    = key;
    kx.i_key_en = 1'b1;
    tick();
    kx.i_key_en = 1'b0;
    kx.i_key    = rnd128();
    for (int s = 0; s < 64; s++) begin
      check("sbox_idx", 64'(kx.o_sbox_idx), 64'(mdl_idx[s]));
      check("sbox_sel", 64'(kx.o_sbox_sel), 64'(mdl_sel[s]));
      if (kx.o_busy !== 1'b1 || kx.o_keyex_en !== 1'b0) bad_ctl++;
      if (s == 63) check("keyex_stable_run", 64'(kx.o_keyex === exp_keyex), 64'd1);
      if (s < 63) tick();
    end
    check("run_busy_en", 64'(bad_ctl), 64'd0);
    tick();
    check("done_keyex_en", 64'(kx.o_keyex_en), 64'd1);
    check("done_busy", 64'(kx.o_busy), 64'd0);
    check("done_sbox_idx", 64'(kx.o_sbox_idx), 64'd0);
    for (int w = 0; w < 32; w++)
      check("keyex_word", 64'(kx.o_keyex[1023-32*w -: 32]), 64'(mdl_keyex[1023-32*w -: 32]));
    exp_keyex = mdl_keyex;
  endtask

  initial begin
    int bad;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 256; i++) sbox_tab[t][i] = $urandom;
    exp_keyex   = '0;
    kx.i_key    = '0;
    kx.i_key_en = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    check("rst_keyex_zero", 64'(kx.o_keyex === 1024'd0), 64'd1);
    check("rst_keyex_en", 64'(kx.o_keyex_en), 64'd0);
    check("rst_busy", 64'(kx.o_busy), 64'd0);
    check("rst_sbox_idx", 64'(kx.o_sbox_idx), 64'd0);
    check("rst_sbox_sel", 64'(kx.o_sbox_sel), 64'd0);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      kx.i_key = rnd128();
      tick();
      if (kx.o_keyex !== 1024'd0 || kx.o_keyex_en !== 1'b0 || kx.o_busy !== 1'b0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    expand(128'h0123456712345678234567893456789A);
    tick();
    check("idle_after_done_en", 64'(kx.o_keyex_en), 64'd0);
    check("idle_after_done_busy", 64'(kx.o_busy), 64'd0);
    check("idle_keyex_held", 64'(kx.o_keyex === exp_keyex), 64'd1);

    // Back-to-back: second key lands in the DONE cycle of the first.
    expand(rnd128());
    expand(rnd128());
    tick();

    // Abort at cycle 30 with an all-zero key.
    kx.i_key    = rnd128();
    kx.i_key_en = 1'b1;
    tick();
    kx.i_key_en = 1'b0;
    bad = 0;
    repeat (29) begin
      if (kx.o_keyex_en !== 1'b0 || kx.o_busy !== 1'b1 || kx.o_keyex !== exp_keyex) bad++;
      tick();
    end
    check("abort_window", 64'(bad), 64'd0);
    expand(128'd0);
    tick();

    // Reset at cycle 40 of an expansion.
    kx.i_key    = rnd128();
    kx.i_key_en = 1'b1;
    tick();
    kx.i_key_en = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    #1;
    check("midrst_keyex_zero", 64'(kx.o_keyex === 1024'd0), 64'd1);
    check("midrst_busy", 64'(kx.o_busy), 64'd0);
    check("midrst_keyex_en", 64'(kx.o_keyex_en), 64'd0);
    check("midrst_sbox_sel", 64'(kx.o_sbox_sel), 64'd0);
    exp_keyex = '0;
    tick();
    rst = 1'b0;
    tick();
    expand(rnd128());
    tick();

    for (int r = 0; r < 3; r++) begin
      expand(rnd128());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
